text_overlay_engine: RTL and testbench
======================================

TEXT_OVERLAY_ENGINE -- requirements
Module: text_overlay_engine

Interface
REQ-001 SHALL have parameter COLS, default 16, meaning character columns.
REQ-002 SHALL have parameter ROWS, default 4, meaning character rows.
REQ-003 SHALL have parameter SCALE, default 1, meaning log2 glyph magnification, legal range 0..3.
REQ-004 SHALL have parameter X0, default 256, meaning region left pixel.
REQ-005 SHALL have parameter Y0, default 128, meaning region top pixel.
REQ-006 SHALL have parameter FG, default 12'h0DD, meaning glyph colour.
REQ-007 SHALL have parameter BG, default 12'h111, meaning in-region background colour.
REQ-008 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per blink phase.
REQ-009 SHALL have ports, in this order:
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- x, y  in  10 each  current pixel coordinates.
- video_on  in  1  active video.
- frame_tick  in  1  one-cycle pulse per frame.
- wr_valid  in  1  cell write request.
- wr_ready  out  1  write accept.
- wr_addr  in  AW = clog2(COLS*ROWS)  cell index, row*COLS+col.
- wr_data  in  8  bit 7 = blink, bits 6:0 = ASCII code.
- clr_req  in  1  clear-buffer request.
- busy  out  1  clear in progress.
- text_on  out  1  pixel is inside the text region.
- text_rgb  out  12  pixel colour.

Function
REQ-010 SHALL hold an N = COLS*ROWS x 8-bit cell buffer and instantiate the existing ascii_rom (11-bit addr {code, glyph_row}, 8-bit data, 1-cycle read latency).
REQ-011 Glyph size SHALL be W = 8<<SCALE by H = 16<<SCALE pixels; in_region = X0<=x<X0+COLS*W and Y0<=y<Y0+ROWS*H.
REQ-012 Addressing SHALL use dx = x-X0 and dy = y-Y0: col = dx>>(3+SCALE), row = dy>>(4+SCALE), glyph_row = (dy>>SCALE)[3:0], bit = (dx>>SCALE)[2:0].
REQ-013 The pixel pipeline SHALL have 3 stages, and outputs for (x,y) sampled at edge n SHALL be valid after edge n+3. The stages are:
- stage 1: registered cell read.
- stage 2: ROM read.
- stage 3: output register.
REQ-014 The pipeline SHALL carry in_region, video_on, bit and the cell blink flag alongside the data, so each output stays aligned with its own pixel.
REQ-015 The pixel SHALL be lit when rom_data[7-bit] = 1 and NOT (blink flag AND blink_phase = 1).
REQ-016 text_on SHALL equal the delayed (in_region AND video_on).
REQ-017 text_rgb SHALL be FG when text_on and lit, BG when text_on and not lit, and 12'h000 otherwise.
REQ-018 The FSM SHALL have two states, IDLE and CLEAR; busy = (state == CLEAR) and wr_ready = NOT busy.
REQ-019 A write SHALL be accepted at a rising edge with wr_valid AND wr_ready; a wr_addr >= N SHALL be accepted and discarded.
REQ-020 In IDLE, clr_req SHALL cause a transition to CLEAR with the clear pointer at 0.
REQ-021 In CLEAR, the block SHALL write 8'h00 to cell ptr on each cycle and increment ptr; after cell N-1 it SHALL return to IDLE, for exactly N busy cycles.
REQ-022 clr_req asserted during CLEAR SHALL be ignored.
REQ-023 wr_valid and clr_req in the same IDLE cycle: the write SHALL complete and CLEAR SHALL start the next cycle, so the cell is later cleared.
REQ-024 Pixel reads SHALL continue during CLEAR and return current buffer contents, partially cleared.
REQ-025 The blink counter SHALL count frame_tick pulses 0..BLINK_FRAMES-1; on wrap it SHALL return to 0 and toggle blink_phase.
REQ-026 Coordinate arithmetic SHALL be at least 11 bits wide so that subtraction underflow is never mistaken for in-region.

Reset
REQ-027 rst_n low SHALL immediately set the following, with no clock required:
- text_on=0, text_rgb=12'h000, all pipeline valids 0.
- blink counter=0, blink_phase=0.
- state=CLEAR, ptr=0.
REQ-028 After reset release, the block SHALL clear all N cells (busy=1, wr_ready=0 for N cycles), so the buffer is always blank at start.
REQ-029 Reset asserted mid-clear or mid-write SHALL restart the clear from ptr=0.

Verification
REQ-030 Reset release -> busy=1 and wr_ready=0 for exactly 64 cycles, then busy=0; a full in-region frame shows only BG (ROM code 0x00 blank).
REQ-031 Write addr 0 = 8'h41; scan x=256..271, y=128..159 -> text_rgb after 3 cycles matches glyph 'A' doubled in both axes (FG/BG).
REQ-032 x=255 or y=256 or video_on=0 -> text_on=0 and text_rgb=12'h000, 3 cycles later; x=256,y=128 -> text_on=1.
REQ-033 Write addr 5 = 8'hC1; 30 frame_tick pulses -> cell 5 shows only BG; 30 more -> 'A' visible again; non-blink cell 0 unaffected throughout.
REQ-034 Same-cycle wr_valid (addr 3, 8'h42) and clr_req in IDLE -> write accepted, busy rises the next cycle for 64 cycles, cell 3 ends 8'h00; clr_req and wr_valid during CLEAR -> no effect.
REQ-035 Drop rst_n during cycle 20 of a clear -> outputs 0 asynchronously; after release busy=1 for a full 64 cycles.

Source files
------------

// File: rtl/text_overlay_engine.sv
`default_nettype none
// ============================================================================
// Module   : text_overlay_engine (plus glyph ROM ascii_rom)
// Purpose  : Character-cell text overlay for a raster video stream. A
//            COLS x ROWS cell buffer (bit 7 = blink, bits 6:0 = ASCII code)
//            is looked up per pixel through a glyph ROM and rendered as FG
//            or BG inside a rectangular region. Three-stage pixel pipeline.
//            The buffer is cleared on reset release and on clr_req.
// Ports    : clk, rst_n (async, active low)
//            x, y, video_on, frame_tick      - raster timing in
//            wr_valid/wr_ready/wr_addr/wr_data - cell write port
//            clr_req / busy                  - buffer clear request/status
//            text_on, text_rgb               - pixel out (3-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// ascii_rom: 8x16 glyph ROM, address {code[6:0], glyph_row[3:0]}, 1-cycle
// registered read. Glyphs not populated here read as blank.
// ----------------------------------------------------------------------------
module ascii_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [7:0] w_data;

  always_comb begin
    w_data = 8'h00;
    case (addr)
      // 'A'
      11'h412: w_data = 8'h10;
      11'h413: w_data = 8'h38;
      11'h414: w_data = 8'h6C;
      11'h415, 11'h416: w_data = 8'hC6;
      11'h417: w_data = 8'hFE;
      11'h418, 11'h419, 11'h41A, 11'h41B: w_data = 8'hC6;
      // 'B'
      11'h422, 11'h42B: w_data = 8'hFC;
      11'h423, 11'h424, 11'h425: w_data = 8'h66;
      11'h426: w_data = 8'h7C;
      11'h427, 11'h428, 11'h429, 11'h42A: w_data = 8'h66;
      default: w_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= w_data;
  end
endmodule

module text_overlay_engine #(
  parameter int          COLS         = 16,
  parameter int          ROWS         = 4,
  parameter int          SCALE        = 1,
  parameter int          X0           = 256,
  parameter int          Y0           = 128,
  parameter logic [11:0] FG           = 12'h0DD,
  parameter logic [11:0] BG           = 12'h111,
  parameter int          BLINK_FRAMES = 30,
  localparam int         AW           = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          video_on,
  input  logic          frame_tick,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr_req,
  output logic          busy,
  output logic          text_on,
  output logic [11:0]   text_rgb
);
  localparam int              c_n          = COLS*ROWS;
  localparam int              c_gw_log2    = 3 + SCALE;
  localparam int              c_gh_log2    = 4 + SCALE;
  localparam logic [31:0]     c_x_lo       = 32'(X0);
  localparam logic [31:0]     c_x_hi       = 32'(X0 + (COLS << c_gw_log2));
  localparam logic [31:0]     c_y_lo       = 32'(Y0);
  localparam logic [31:0]     c_y_hi       = 32'(Y0 + (ROWS << c_gh_log2));
  localparam logic [AW:0]     c_n_ext      = (AW+1)'(c_n);
  localparam logic [AW-1:0]   c_last       = AW'(c_n - 1);
  localparam int              c_bw         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_bw-1:0] c_blink_last = c_bw'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic          w_addr_ok;

  logic [7:0]    r_mem [c_n];

  logic [c_bw-1:0] r_blink_cnt;
  logic            r_blink_phase;

  // Coordinate arithmetic is 32 bits wide so that x < X0 wraps to a huge
  // value rather than aliasing into the region; in_region gates everything.
  logic [31:0]   w_x, w_y, w_dx, w_dy, w_sdx, w_sdy, w_idx;
  logic          w_in_region;
  logic [AW-1:0] w_rd_addr;
  logic          w_unused_bits;

  logic [7:0]    r1_cell;
  logic [3:0]    r1_grow;
  logic [2:0]    r1_bit;
  logic          r1_in, r1_von;
  logic [2:0]    r2_bit;
  logic          r2_blink, r2_in, r2_von;
  logic [7:0]    w_rom_data;
  logic          w_lit;

  // --------------------------------------------------------------------------
  // Clear FSM and single buffer write port
  // --------------------------------------------------------------------------
  assign busy      = (r_state == S_CLEAR);
  assign wr_ready  = ~busy;
  assign w_addr_ok = ({1'b0, wr_addr} < c_n_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_waddr     = wr_addr;
    w_wdata     = wr_data;
    case (r_state)
      S_IDLE: begin
        // A same-cycle write still lands; the clear that follows erases it.
        w_we = wr_valid & w_addr_ok;
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_ptr;
        w_wdata = 8'h00;
        if (r_ptr == c_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Blink timebase
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel address generation
  // --------------------------------------------------------------------------
  assign w_x         = {22'd0, x};
  assign w_y         = {22'd0, y};
  assign w_in_region = (w_x >= c_x_lo) && (w_x < c_x_hi) &&
                       (w_y >= c_y_lo) && (w_y < c_y_hi);
  assign w_dx        = w_x - c_x_lo;
  assign w_dy        = w_y - c_y_lo;
  assign w_sdx       = w_dx >> SCALE;
  assign w_sdy       = w_dy >> SCALE;
  assign w_idx       = (w_dy >> c_gh_log2) * 32'(COLS) + (w_dx >> c_gw_log2);
  assign w_rd_addr   = w_in_region ? w_idx[AW-1:0] : '0;

  assign w_unused_bits = ^{w_idx[31:AW], w_sdx[31:3], w_sdy[31:4]};

  // --------------------------------------------------------------------------
  // Pipeline: cell read -> glyph ROM -> output register
  // --------------------------------------------------------------------------
  ascii_rom u_rom (
    .clk  (clk),
    .addr ({r1_cell[6:0], r1_grow}),
    .data (w_rom_data)
  );

  // Blink suppresses lit pixels only during phase 1.
  assign w_lit = w_rom_data[3'd7 - r2_bit] & ~(r2_blink & r_blink_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_cell  <= '0;
      r1_grow  <= '0;
      r1_bit   <= '0;
      r1_in    <= 1'b0;
      r1_von   <= 1'b0;
      r2_bit   <= '0;
      r2_blink <= 1'b0;
      r2_in    <= 1'b0;
      r2_von   <= 1'b0;
      text_on  <= 1'b0;
      text_rgb <= 12'h000;
    end else begin
      r1_cell  <= r_mem[w_rd_addr];
      r1_grow  <= w_sdy[3:0];
      r1_bit   <= w_sdx[2:0];
      r1_in    <= w_in_region;
      r1_von   <= video_on;
      r2_bit   <= r1_bit;
      r2_blink <= r1_cell[7];
      r2_in    <= r1_in;
      r2_von   <= r1_von;
      text_on  <= r2_in & r2_von;
      text_rgb <= (r2_in & r2_von) ? (w_lit ? FG : BG) : 12'h000;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_text_overlay_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_overlay_engine
// Purpose  : Directed self-checking bench for text_overlay_engine with
//            default parameters (16x4 cells, SCALE=1, region 256..511 x
//            128..255). Expected pixels come from a local copy of glyph 'A'.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_overlay_engine;
  localparam logic [11:0] FG_C = 12'h0DD;
  localparam logic [11:0] BG_C = 12'h111;

  logic        clk;
  logic        rst_n      = 1'b1;
  logic [9:0]  x          = '0;
  logic [9:0]  y          = '0;
  logic        video_on   = 1'b0;
  logic        frame_tick = 1'b0;
  logic        wr_valid   = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr    = '0;
  logic [7:0]  wr_data    = '0;
  logic        clr_req    = 1'b0;
  logic        busy;
  logic        text_on;
  logic [11:0] text_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  text_overlay_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .busy       (busy),
    .text_on    (text_on),
    .text_rgb   (text_rgb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected colour of pixel (px,py) for an 'A' cell whose left edge is cx0.
  function automatic logic [11:0] exp_a(input int px, input int py, input int cx0);
    logic [7:0] r;
    int b;
    r = glyph_a[((py - 128) >> 1) & 15];
    b = ((px - cx0) >> 1) & 7;
    return r[7-b] ? FG_C : BG_C;
  endfunction

  task automatic set_px(input int px, input int py, input logic von);
    x        = 10'(px);
    y        = 10'(py);
    video_on = von;
  endtask

  task automatic wait_pipe();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = 6'(a);
    wr_data  = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    int cnt;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: text_on=%b text_rgb=%h, want 0/000", text_on, text_rgb);
    end
    n_checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%b wr_ready=%b, want 1/0", busy, wr_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) begin
        n_checks++;
        if (wr_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_ready_low: wr_ready=%b, want 0", wr_ready);
        end
      end
    end while (busy === 1'b1 && cnt < 200);
    n_checks++;
    if (cnt != 64) begin
      n_fail++;
      $display("FAIL reset_clear_len: busy cycles=%0d, want 64", cnt);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_high: wr_ready=%b, want 1", wr_ready);
    end
    // Blank buffer: every 4th line of the region shows BG only.
    for (int s = 0; s < 8192 + 3; s++) begin
      if (s >= 3) begin
        n_checks++;
        if (text_on !== 1'b1 || text_rgb !== BG_C) begin
          n_fail++;
          $display("FAIL blank_frame px=%0d,%0d: on=%b rgb=%h, want 1/%h",
                   256 + (s-3) % 256, 128 + 4*((s-3) / 256), text_on, text_rgb, BG_C);
        end
      end
      if (s < 8192) set_px(256 + s % 256, 128 + 4*(s / 256), 1'b1);
      @(posedge clk);
      #1;
    end
    video_on = 1'b0;
  endtask

  task automatic test_glyph();
    logic [11:0] e;
    do_write(0, 8'h41);
    for (int s = 0; s < 512 + 3; s++) begin
      if (s >= 3) begin
        e = exp_a(256 + (s-3) % 16, 128 + (s-3) / 16, 256);
        n_checks++;
        if (text_on !== 1'b1 || text_rgb !== e) begin
          n_fail++;
          $display("FAIL glyph_scan px=%0d,%0d: on=%b rgb=%h, want 1/%h",
                   256 + (s-3) % 16, 128 + (s-3) / 16, text_on, text_rgb, e);
        end
      end
      if (s < 512) set_px(256 + s % 16, 128 + s / 16, 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_outside();
    int px [7] = '{255, 256, 256, 256, 511, 0, 512};
    int py [7] = '{128, 256, 128, 128, 255, 0, 128};
    logic vo [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic eon [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] ergb [7] = '{12'h000, 12'h000, 12'h000, BG_C, BG_C, 12'h000, 12'h000};
    for (int i = 0; i < 7; i++) begin
      set_px(px[i], py[i], vo[i]);
      wait_pipe();
      n_checks++;
      if (text_on !== eon[i] || text_rgb !== ergb[i]) begin
        n_fail++;
        $display("FAIL edge_%0d px=%0d,%0d von=%b: on=%b rgb=%h, want %b/%h",
                 i, px[i], py[i], vo[i], text_on, text_rgb, eon[i], ergb[i]);
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_blink();
    do_write(5, 8'hC1);
    set_px(338, 142, 1'b1);
    wait_pipe();
    n_checks++;
    if (text_rgb !== FG_C) begin
      n_fail++;
      $display("FAIL blink_phase0: rgb=%h, want %h", text_rgb, FG_C);
    end
    tick_n(29);
    wait_pipe();
    n_checks++;
    if (text_rgb !== FG_C) begin
      n_fail++;
      $display("FAIL blink_29_ticks: rgb=%h, want %h", text_rgb, FG_C);
    end
    tick_n(1);
    wait_pipe();
    n_checks++;
    if (text_rgb !== BG_C) begin
      n_fail++;
      $display("FAIL blink_30_ticks: rgb=%h, want %h", text_rgb, BG_C);
    end
    set_px(258, 142, 1'b1);
    wait_pipe();
    n_checks++;
    if (text_rgb !== FG_C) begin
      n_fail++;
      $display("FAIL blink_cell0_steady: rgb=%h, want %h", text_rgb, FG_C);
    end
    for (int s = 0; s < 512 + 3; s++) begin
      if (s >= 3) begin
        n_checks++;
        if (text_on !== 1'b1 || text_rgb !== BG_C) begin
          n_fail++;
          $display("FAIL blink_cell5_hidden px=%0d,%0d: on=%b rgb=%h, want 1/%h",
                   336 + (s-3) % 16, 128 + (s-3) / 16, text_on, text_rgb, BG_C);
        end
      end
      if (s < 512) set_px(336 + s % 16, 128 + s / 16, 1'b1);
      @(posedge clk);
      #1;
    end
    tick_n(30);
    set_px(338, 142, 1'b1);
    wait_pipe();
    n_checks++;
    if (text_rgb !== FG_C) begin
      n_fail++;
      $display("FAIL blink_60_ticks: rgb=%h, want %h", text_rgb, FG_C);
    end
    set_px(258, 142, 1'b1);
    wait_pipe();
    n_checks++;
    if (text_rgb !== FG_C) begin
      n_fail++;
      $display("FAIL blink_cell0_after: rgb=%h, want %h", text_rgb, FG_C);
    end
    video_on = 1'b0;
  endtask

  task automatic test_write_clear();
    int i;
    int cpx [3] = '{304, 290, 258};
    int cpy [3] = '{132, 142, 142};
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wc_ready_idle: wr_ready=%b, want 1", wr_ready);
    end
    wr_valid = 1'b1;
    wr_addr  = 6'd3;
    wr_data  = 8'h42;
    clr_req  = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wc_busy_rise: busy=%b, want 1", busy);
    end
    // Cell 3 ('B', row 2 = FC, bit 0 lit) is read before the clear reaches it.
    set_px(304, 132, 1'b1);
    i = 0;
    while (busy === 1'b1 && i < 200) begin
      if (i == 3) begin
        n_checks++;
        if (text_on !== 1'b1 || text_rgb !== FG_C) begin
          n_fail++;
          $display("FAIL wc_cell3_written: on=%b rgb=%h, want 1/%h", text_on, text_rgb, FG_C);
        end
      end
      if (i == 10) begin
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 6'd2;
        wr_data  = 8'h41;
      end
      if (i == 11) begin
        n_checks++;
        if (wr_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL wc_ready_clear: wr_ready=%b, want 0", wr_ready);
        end
      end
      if (i == 13) begin
        clr_req  = 1'b0;
        wr_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      i++;
    end
    n_checks++;
    if (i != 64) begin
      n_fail++;
      $display("FAIL wc_clear_len: busy cycles=%0d, want 64", i);
    end
    for (int k = 0; k < 3; k++) begin
      set_px(cpx[k], cpy[k], 1'b1);
      wait_pipe();
      n_checks++;
      if (text_on !== 1'b1 || text_rgb !== BG_C) begin
        n_fail++;
        $display("FAIL wc_cleared_%0d px=%0d,%0d: on=%b rgb=%h, want 1/%h",
                 k, cpx[k], cpy[k], text_on, text_rgb, BG_C);
      end
    end
  endtask

  task automatic test_reset_midclear();
    int cnt;
    set_px(300, 140, 1'b1);
    wait_pipe();
    n_checks++;
    if (text_on !== 1'b1 || text_rgb !== BG_C) begin
      n_fail++;
      $display("FAIL mc_precond: on=%b rgb=%h, want 1/%h", text_on, text_rgb, BG_C);
    end
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_async_reset: on=%b rgb=%h busy=%b, want 0/000/1", text_on, text_rgb, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (busy === 1'b1 && cnt < 200);
    n_checks++;
    if (cnt != 64) begin
      n_fail++;
      $display("FAIL mc_clear_len: busy cycles=%0d, want 64", cnt);
    end
    video_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glyph();
    test_outside();
    test_blink();
    test_write_clear();
    test_reset_midclear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
